// File: rtl/pattern_tx_if.sv
// Load port and serial output bundle for pattern_tx.
// The master drives the load request; the slave (the transmitter) drives the serial line.
interface pattern_tx_if #(
    parameter int WIDTH = 16
);
    localparam int LW = $clog2(WIDTH + 1);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] pattern;
    logic [LW-1:0]    len;
    logic [3:0]       rpt;
    logic             abort;
    logic             op;
    logic             op_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, pattern, len, rpt, abort,
        input  load_ready, op, op_valid, busy, done
    );

    modport slave (
        input  load_valid, pattern, len, rpt, abort,
        output load_ready, op, op_valid, busy, done
    );
endinterface

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a captured word MSB-first, one bit per clock,
// repeating the frame rpt extra times with GAP idle cycles between frames.
module pattern_tx #(
    parameter int WIDTH = 16,
    parameter int GAP   = 1
) (
    input logic         clk,
    input logic         reset,
    pattern_tx_if.slave tx
);
    localparam int LW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LW-1:0]    len_q, len_d;
    logic [LW-1:0]    idx_q, idx_d;
    logic [3:0]       frm_q, frm_d;
    logic [3:0]       gap_q, gap_d;
    logic [LW-1:0]    eff_len;
    logic [WIDTH-1:0] bit_mask;

    // Out-of-range lengths fall back to the full word.
    always_comb begin
        if (tx.len == '0 || tx.len > LW'(WIDTH)) begin
            eff_len = LW'(WIDTH);
        end else begin
            eff_len = tx.len;
        end
    end

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        idx_d   = idx_q;
        frm_d   = frm_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (tx.load_valid) begin
                    pat_d   = tx.pattern;
                    len_d   = eff_len;
                    idx_d   = eff_len - LW'(1);
                    frm_d   = tx.rpt;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (tx.abort) begin
                    state_d = S_IDLE;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - LW'(1);
                end else if (frm_q != '0) begin
                    frm_d = frm_q - 4'd1;
                    if (GAP == 0) begin
                        idx_d = len_q - LW'(1);
                    end else begin
                        gap_d   = 4'(GAP - 1);
                        state_d = S_GAP;
                    end
                end else begin
                    state_d = S_FIN;
                end
            end
            S_GAP: begin
                if (tx.abort) begin
                    state_d = S_IDLE;
                end else if (gap_q == '0) begin
                    idx_d   = len_q - LW'(1);
                    state_d = S_SEND;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            frm_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            frm_q   <= frm_d;
            gap_q   <= gap_d;
        end
    end

    // Captured word is only observed while SEND is active, so it needs no reset.
    always_ff @(posedge clk) begin
        pat_q <= pat_d;
        len_q <= len_d;
    end

    assign bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << idx_q;

    assign tx.load_ready = (state_q == S_IDLE);
    assign tx.op_valid   = (state_q == S_SEND);
    assign tx.op         = (state_q == S_SEND) && |(pat_q & bit_mask);
    assign tx.busy       = (state_q == S_SEND) || (state_q == S_GAP);
    assign tx.done       = (state_q == S_FIN);
endmodule

// File: tb/tb_pattern_tx.sv
// Bench for pattern_tx: directed and random transfers compared cycle by cycle
// against a per-cycle output list built from the frame/gap/repeat rules.
module tb_pattern_tx;
    localparam int WIDTH = 16;
    localparam int GAPC  = 1;
    localparam logic [4:0] IDLE_V = 5'b00001;   // {op, op_valid, busy, done, load_ready}
    localparam logic [4:0] GAP_V  = 5'b00100;
    localparam logic [4:0] FIN_V  = 5'b00010;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    logic [4:0] exp_q[$];

    pattern_tx_if #(.WIDTH(WIDTH)) tx ();

    pattern_tx #(.WIDTH(WIDTH), .GAP(GAPC)) dut (
        .clk   (clk),
        .reset (reset),
        .tx    (tx.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] obs();
        return {tx.op, tx.op_valid, tx.busy, tx.done, tx.load_ready};
    endfunction

    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] want);
        n_chk++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, want);
        end
    endtask

    // Expected outputs per cycle after the accepting edge; ab_at truncates at an abort.
    task automatic build_model(input logic [15:0] p, input logic [4:0] ln, input int r,
                               input int ab_at);
        int L;
        exp_q.delete();
        L = (ln == 0 || ln > WIDTH) ? WIDTH : int'(ln);
        for (int f = 0; f <= r; f++) begin
            for (int k = 0; k < L; k++) exp_q.push_back({p[L-1-k], 1'b1, 1'b1, 2'b00});
            if (f < r) for (int g = 0; g < GAPC; g++) exp_q.push_back(GAP_V);
        end
        exp_q.push_back(FIN_V);
        exp_q.push_back(IDLE_V);
        if (ab_at >= 0) begin
            while (exp_q.size() > ab_at + 1) void'(exp_q.pop_back());
            exp_q.push_back(IDLE_V);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the final idle cycle.
    task automatic send(input string tag, input logic [15:0] p, input logic [4:0] ln,
                        input int r, input int ab_at, input bit ab_on_load);
        build_model(p, ln, r, ab_at);
        tx.load_valid = 1'b1;
        tx.pattern    = p;
        tx.len        = ln;
        tx.rpt        = 4'(r);
        tx.abort      = ab_on_load;
        @(posedge clk);
        #1;
        tx.abort   = 1'b0;
        tx.pattern = 16'($urandom);
        tx.len     = 5'($urandom);
        tx.rpt     = 4'($urandom);
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clk);
            chk(tag, obs(), exp_q[c]);
            if (c == ab_at) tx.abort = 1'b1;
            else            tx.abort = (exp_q[c] == FIN_V);
            if (exp_q[c][0]) tx.load_valid = 1'b0;
            else             tx.load_valid = 1'($urandom_range(0, 1));
        end
        tx.abort      = 1'b0;
        tx.load_valid = 1'b0;
    endtask

    initial begin
        int n_bits;
        int ab;
        logic [4:0] rl;
        int rr;
        n_chk  = 0;
        n_fail = 0;
        reset         = 1'b0;
        tx.load_valid = 1'b0;
        tx.pattern    = '0;
        tx.len        = '0;
        tx.rpt        = '0;
        tx.abort      = 1'b0;

        repeat (3) begin
            @(negedge clk);
            chk("reset_hold", obs(), IDLE_V);
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_stable", obs(), IDLE_V);
        end

        send("single_frame", 16'h000D, 5'd4, 0, -1, 1'b0);
        send("repeat_gap",   16'h000D, 5'd4, 2, -1, 1'b0);
        send("len_clamp0",   16'h8001, 5'd0, 0, -1, 1'b0);
        send("len_clamp20",  16'hA5C3, 5'd20, 1, -1, 1'b0);
        send("abort_f1b1",   16'h000D, 5'd4, 3, 6, 1'b0);
        send("after_abort",  16'h0005, 5'd3, 0, -1, 1'b0);
        send("abort_in_gap", 16'h0003, 5'd2, 2, 2, 1'b0);
        send("load_w_abort", 16'h0006, 5'd3, 1, -1, 1'b1);

        // Asynchronous reset dropped between edges while sending
        tx.load_valid = 1'b1;
        tx.pattern    = 16'hFFFF;
        tx.len        = 5'd8;
        tx.rpt        = 4'd1;
        @(posedge clk);
        #1;
        tx.load_valid = 1'b0;
        @(negedge clk);
        chk("pre_async_send", obs(), 5'b11100);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_now", obs(), IDLE_V);
        @(negedge clk);
        chk("async_reset_hold", obs(), IDLE_V);
        reset = 1'b1;
        @(negedge clk);
        chk("after_release", obs(), IDLE_V);
        send("post_reset_len2", 16'h0002, 5'd2, 0, -1, 1'b0);

        for (int t = 0; t < 10; t++) begin
            rl     = 5'($urandom_range(0, 20));
            rr     = $urandom_range(0, 3);
            n_bits = (rl == 0 || rl > WIDTH) ? WIDTH : int'(rl);
            ab     = -1;
            if ($urandom_range(0, 2) == 0)
                ab = $urandom_range(0, (rr + 1) * n_bits + rr * GAPC - 1);
            send("random", 16'($urandom), rl, rr, ab, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pattern_tx.md
# pattern_tx

Serial bit-pattern transmitter: accepts a parallel pattern word through a valid/ready load port and drives it MSB-first, one bit per clock, onto a serial line, optionally repeating the frame with idle gaps between repeats. It sits upstream of the team's Moore sequence detectors, generating the serial `ip` stimulus they consume. All outputs are Moore outputs, decoded from registered state only.

## Interface
- `WIDTH`, 16: maximum pattern length in bits (2..32).
- `GAP`, 1: idle cycles inserted between repeated frames (0..15; 0 = back-to-back).
- `LW`, derived `$clog2(WIDTH+1)`: width of `len`.
- `clk` in 1: single clock; all state changes on rising edge.
- `reset` in 1: asynchronous, active-low; low forces IDLE immediately.
- `load_valid` in 1: load request.
- `load_ready` out 1: high only in IDLE.
- `pattern` in WIDTH: bits to send; only `pattern[len-1:0]` used.
- `len` in LW: frame length; 0 or >WIDTH is treated as WIDTH.
- `rpt` in 4: extra repeats; total frames = `rpt`+1.
- `abort` in 1: terminate current transfer.
- `op` out 1: serial data bit.
- `op_valid` out 1: `op` carries a pattern bit this cycle.
- `busy` out 1: high in SEND and GAP.
- `done` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, SEND, GAP, FIN.
- IDLE: `load_ready`=1, `op`=0, `op_valid`=0, `busy`=0, `done`=0. On `load_valid`: capture `pattern`, effective length L, `rpt`; bit index = L-1, frame counter = `rpt` -> SEND.
- SEND: `op`=captured[index], `op_valid`=1, `busy`=1. Each edge index decrements. At index 0: if `abort` -> IDLE; else if frames remaining > 0 -> GAP (or directly back to SEND with index L-1 when `GAP`=0), decrement frame counter; else -> FIN.
- GAP: `op`=0, `op_valid`=0, `busy`=1 for exactly `GAP` cycles, then SEND with index L-1.
- FIN: `done`=1, `busy`=0, `load_ready`=0, `op_valid`=0; one cycle -> IDLE.
- `abort` sampled high in SEND or GAP -> IDLE next edge; no `done` pulse. `abort` in IDLE/FIN ignored. `abort` and `load_valid` both high in IDLE: load is accepted (abort ignored).
- `load_valid` while not IDLE is ignored; captured data is never modified mid-transfer.
- Reset value of every output: `load_ready`=1, all others 0. Reset asserted mid-transfer: outputs to reset values asynchronously, captured data discarded, no `done`.

## Timing
- Load accepted at edge E0 (`load_valid`&&`load_ready`). First bit `pattern[L-1]` valid in the cycle after E0; bit k of frame (k=0 first) in cycle E0+1+k.
- Frame f (f=0 first) starts at cycle E0+1+f*(L+GAP).
- `done` high in cycle E0+1+(rpt+1)*L+rpt*GAP; `load_ready` returns the following cycle. Earliest next acceptance is that cycle's edge.
- Latency load->first bit: 1 cycle. No combinational path from inputs to outputs.
- Counters: index LW bits, gap counter 4 bits, frame counter 4 bits; none wraps in legal operation.

## Test plan
- Reset: hold `reset`=0 3 cycles -> `load_ready`=1, `op`/`op_valid`/`busy`/`done`=0; release, idle stays stable.
- Single frame: `pattern`=16'h000D, `len`=4, `rpt`=0 -> `op`=1,1,0,1 with `op_valid`=1 in cycles E0+1..E0+4, `done` at E0+5, `load_ready` at E0+6.
- Repeats with gap: same pattern, `rpt`=2, `GAP`=1 -> `op_valid` pattern 1111 0 1111 0 1111, `op` 1101 0 1101 0 1101, `done` at E0+15.
- Length clamp: `len`=0, `pattern`=16'h8001 -> 16 bits sent, first `op`=1, then fourteen 0s, last 1; `done` at E0+17.
- Abort: `rpt`=3, assert `abort` during second bit of frame 1 -> IDLE next cycle, `op_valid`=0, `done` never pulses; new load accepted immediately after.
- Async reset mid-frame: drop `reset` between edges in SEND -> outputs reset immediately; after release, `load_valid` with `len`=2, `pattern`=2'b10 sends 1,0 correctly.
